// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential radix-2 divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int DIV_WIDTH = 64;
    // Widest operand the negate helper handles; callers size-cast in and out.
    localparam int DIV_MAX_W = 128;

    function automatic logic [DIV_MAX_W-1:0] cond_negate(input logic [DIV_MAX_W-1:0] val,
                                                         input logic                 neg);
        logic [DIV_MAX_W-1:0] res;
        if (neg) begin
            res = ~val + {{(DIV_MAX_W-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    // The true difference is below the divisor, so the low WIDTH bits are exact.
    assign w_diff  = w_shift[WIDTH-1:0] - i_dvs;

    // Compare-and-restore selection.
    always_comb begin
        o_q   = 1'b0;
        o_rem = w_shift[WIDTH-1:0];
        if (w_shift >= {1'b0, i_dvs}) begin
            o_q   = 1'b1;
            o_rem = w_diff;
        end else begin
            o_q   = 1'b0;
            o_rem = w_shift[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider with valid/ready handshakes,
// one quotient bit per cycle and a defined divide-by-zero result.
module seq_divider
    import div_pkg::*;
#(
    parameter  int WIDTH = DIV_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e       r_state;
    div_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem, r_dvd, r_dvs, r_quotient, r_remainder;
    logic             r_neg_q, r_neg_r, r_dbz;

    logic             w_in_ready, w_accept, w_dvs_zero, w_dvd_neg, w_dvs_neg, w_step_q;
    logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag, w_step_rem, w_quo_fix, w_rem_fix;

    assign w_dvd_neg  = in_signed & dividend[WIDTH-1];
    assign w_dvs_neg  = in_signed & divisor[WIDTH-1];
    assign w_dvs_zero = (divisor == '0);
    assign w_dvd_mag  = WIDTH'(cond_negate(DIV_MAX_W'(dividend), w_dvd_neg));
    assign w_dvs_mag  = WIDTH'(cond_negate(DIV_MAX_W'(divisor), w_dvs_neg));
    assign w_quo_fix  = WIDTH'(cond_negate(DIV_MAX_W'(r_dvd), r_neg_q));
    assign w_rem_fix  = WIDTH'(cond_negate(DIV_MAX_W'(r_rem), r_neg_r));

    // The dividend register doubles as the quotient shift register.
    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_bit (r_dvd[WIDTH-1]),
        .i_dvs (r_dvs),
        .o_rem (w_step_rem),
        .o_q   (w_step_q)
    );

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
        w_accept    = in_valid && w_in_ready;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_dvs_zero ? DONE : RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = FIX;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            FIX:     w_state_nxt = DONE;
            DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_dvs_zero ? DONE : RUN;
                end else if (out_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dbz       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (w_accept) begin
            r_cnt   <= CNT_W'(WIDTH - 1);
            r_rem   <= '0;
            r_dvd   <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
            r_dbz   <= w_dvs_zero;
            if (w_dvs_zero) begin
                r_quotient  <= '1;
                r_remainder <= dividend;
            end
        end else if (r_state == RUN) begin
            r_rem <= w_step_rem;
            r_dvd <= {r_dvd[WIDTH-2:0], w_step_q};
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end else if (r_state == FIX) begin
            r_quotient  <= w_quo_fix;
            r_remainder <= w_rem_fix;
            r_dbz       <= 1'b0;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at WIDTH=8 and WIDTH=64.
module tb_seq_divider;

    logic        clk;
    int          tests_run;
    int          tests_failed;

    logic        rst8, iv8, ir8, sg8, ov8, or8, z8;
    logic [7:0]  dd8, ds8, q8, r8;
    logic        rst64, iv64, ir64, sg64, ov64, or64, z64;
    logic [63:0] dd64, ds64, q64, r64;
    int          lat;

    seq_divider #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(rst8), .in_valid(iv8), .in_ready(ir8), .in_signed(sg8),
        .dividend(dd8), .divisor(ds8), .out_valid(ov8), .out_ready(or8),
        .quotient(q8), .remainder(r8), .div_by_zero(z8)
    );

    seq_divider #(.WIDTH(64)) u_dut64 (
        .clk(clk), .reset(rst64), .in_valid(iv64), .in_ready(ir64), .in_signed(sg64),
        .dividend(dd64), .divisor(ds64), .out_valid(ov64), .out_ready(or64),
        .quotient(q64), .remainder(r64), .div_by_zero(z64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start8(input logic s, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        check_eq("in_ready8", {63'd0, ir8}, 64'd1);
        sg8 = s; dd8 = a; ds8 = b; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic wait8(output int n);
        n = 0;
        while (ov8 !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic consume8();
        @(negedge clk);
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        check_eq("ov8_drop", {63'd0, ov8}, 64'd0);
    endtask

    task automatic run8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ez, input int elat);
        int n;
        start8(s, a, b);
        wait8(n);
        check_eq({tag, "/lat"}, 64'(n), 64'(elat));
        check_eq({tag, "/q"}, {56'd0, q8}, {56'd0, eq});
        check_eq({tag, "/r"}, {56'd0, r8}, {56'd0, er});
        check_eq({tag, "/dbz"}, {63'd0, z8}, {63'd0, ez});
        consume8();
    endtask

    task automatic start64(input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        sg64 = 1'b0; dd64 = a; ds64 = b; iv64 = 1'b1;
        @(posedge clk); #1;
        iv64 = 1'b0;
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst8 = 1'b1; iv8 = 1'b0; sg8 = 1'b0; dd8 = 8'd0; ds8 = 8'd0; or8 = 1'b0;
        rst64 = 1'b1; iv64 = 1'b0; sg64 = 1'b0; dd64 = 64'd0; ds64 = 64'd0; or64 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst/ov8", {63'd0, ov8}, 64'd0);
        check_eq("rst/ir8", {63'd0, ir8}, 64'd1);
        check_eq("rst/q8", {56'd0, q8}, 64'd0);
        check_eq("rst/r8", {56'd0, r8}, 64'd0);
        check_eq("rst/z8", {63'd0, z8}, 64'd0);
        @(negedge clk);
        rst8 = 1'b0; rst64 = 1'b0;

        run8("u200_7",  1'b0, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 9);
        run8("s-100_7", 1'b1, 8'h9C,  8'h07,  8'hF2,  8'hFE,  1'b0, 9);
        run8("s100_-7", 1'b1, 8'h64,  8'hF9,  8'hF2,  8'h02,  1'b0, 9);
        run8("s-100_-7",1'b1, 8'h9C,  8'hF9,  8'h0E,  8'hFE,  1'b0, 9);
        run8("dbz_u",   1'b0, 8'h5A,  8'h00,  8'hFF,  8'h5A,  1'b1, 0);
        run8("s_ovf",   1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 9);
        run8("dbz_s",   1'b1, 8'h9C,  8'h00,  8'hFF,  8'h9C,  1'b1, 0);
        run8("u80_ff",  1'b0, 8'h80,  8'hFF,  8'h00,  8'h80,  1'b0, 9);
        run8("uff_10",  1'b0, 8'hFF,  8'h10,  8'h0F,  8'h0F,  1'b0, 9);
        run8("u5_9",    1'b0, 8'h05,  8'h09,  8'h00,  8'h05,  1'b0, 9);

        // Back-pressure: result held while a pending operand waits.
        start8(1'b0, 8'd50, 8'd5);
        wait8(lat);
        check_eq("bp/q", {56'd0, q8}, 64'd10);
        @(negedge clk);
        sg8 = 1'b0; dd8 = 8'd77; ds8 = 8'd9; iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp/hold_ov", {63'd0, ov8}, 64'd1);
            check_eq("bp/hold_ir", {63'd0, ir8}, 64'd0);
            check_eq("bp/hold_q", {56'd0, q8}, 64'd10);
            check_eq("bp/hold_r", {56'd0, r8}, 64'd0);
        end
        @(negedge clk);
        or8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0; or8 = 1'b0;
        check_eq("b2b/ov_low", {63'd0, ov8}, 64'd0);
        wait8(lat);
        check_eq("b2b/lat", 64'(lat), 64'd9);
        check_eq("b2b/q", {56'd0, q8}, 64'd8);
        check_eq("b2b/r", {56'd0, r8}, 64'd5);
        consume8();

        // Zero divisor accepted straight out of DONE stays in DONE.
        start8(1'b0, 8'h11, 8'h00);
        @(negedge clk);
        or8 = 1'b1; iv8 = 1'b1; sg8 = 1'b0; dd8 = 8'h33; ds8 = 8'h00;
        @(posedge clk); #1;
        iv8 = 1'b0; or8 = 1'b0;
        check_eq("dbz2/ov", {63'd0, ov8}, 64'd1);
        check_eq("dbz2/r", {56'd0, r8}, 64'h33);
        check_eq("dbz2/z", {63'd0, z8}, 64'd1);
        consume8();

        // WIDTH=64: load non-zero outputs, then reset in the middle of a run.
        start64(64'h1234, 64'd0);
        check_eq("w64/dbz_q", q64, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        or64 = 1'b1;
        @(posedge clk); #1;
        or64 = 1'b0;
        start64(64'hFFFF_FFFF_FFFF_FFFF, 64'd7);
        repeat (10) @(posedge clk);
        #1;
        check_eq("w64/midrun_ov", {63'd0, ov64}, 64'd0);
        @(negedge clk);
        rst64 = 1'b1;
        @(posedge clk); #1;
        check_eq("w64rst/ov", {63'd0, ov64}, 64'd0);
        check_eq("w64rst/ir", {63'd0, ir64}, 64'd1);
        check_eq("w64rst/q", q64, 64'd0);
        check_eq("w64rst/r", r64, 64'd0);
        check_eq("w64rst/z", {63'd0, z64}, 64'd0);
        @(negedge clk);
        rst64 = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        check_eq("w64/discarded", {63'd0, ov64}, 64'd0);

        start64(64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
        lat = 0;
        while (ov64 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("w64/lat", 64'(lat), 64'd65);
        check_eq("w64/q", q64, 64'h5555_5555_5555_5555);
        check_eq("w64/r", r64, 64'd0);
        check_eq("w64/z", {63'd0, z64}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle radix-2 restoring divider producing quotient and remainder, with signed/unsigned mode and a defined divide-by-zero result. It replaces the fixed 64-bit quotient-only divider in the arithmetic datapath. Operands are taken and results returned through valid/ready handshakes so upstream and downstream logic can stall. One quotient bit is resolved per cycle.

## Interface
- WIDTH, 64: operand, quotient and remainder width (≥ 4).
- CNT_W, $clog2(WIDTH): iteration counter width (derived, not overridden).
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set present.
- in_ready  out  1  divider can accept operands this cycle.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- dividend  in  WIDTH  numerator, sampled at accept.
- divisor  in  WIDTH  denominator, sampled at accept.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer takes the result this cycle.
- quotient  out  WIDTH  result quotient.
- remainder  out  WIDTH  result remainder.
- div_by_zero  out  1  divisor was zero for this result.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Accept: in_valid && in_ready at an edge. in_ready = (state == IDLE) || (state == DONE && out_ready).
- On accept: latch sign flags and operand magnitudes (negate negative inputs when in_signed). Clear the partial remainder. Load counter = WIDTH-1. Divisor == 0 goes to DONE; otherwise go to RUN.
- RUN, per edge: shift {partial_rem, dividend_mag} left by 1. If the shifted partial_rem (WIDTH+1 bits) ≥ divisor_mag, subtract and set the new quotient LSB = 1, else 0. At counter == 0 go to FIX, else decrement.
- FIX: quotient negated if signed and operand signs differ. Remainder negated if signed and dividend negative. Go to DONE.
- DONE: out_valid = 1, outputs held stable until out_ready. Transitions:
  - out_ready without a new accept → IDLE.
  - out_ready with a simultaneous accept → RUN (or DONE again for zero divisor).
- Divide-by-zero: quotient = all ones, remainder = original dividend (unmodified bits), div_by_zero = 1.
- Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0, div_by_zero = 0. This falls out of the unsigned magnitude path; no special case.
- Operand inputs are ignored outside accept edges. in_signed = 0 never negates.
- Reset at any point: state = IDLE. quotient, remainder, div_by_zero, out_valid = 0. Internal registers cleared. Any in-flight operation is discarded without output.

## Timing
- Normal latency: out_valid rises WIDTH+1 edges after the accepting edge (WIDTH RUN edges + 1 FIX edge).
- Divide-by-zero latency: out_valid on the edge after accept.
- Throughput: one result per WIDTH+1 cycles with out_ready held high (back-to-back accept in DONE).
- in_ready and out_valid are combinational only from state and out_ready. No combinational path from operand data to any output.
- out_valid deasserts on the edge after out_ready && out_valid unless a new zero-divisor op completes.

## Structure
- Package div_pkg: state enum (IDLE, RUN, FIX, DONE), default width constant DIV_WIDTH = 64, helper function for conditional two's-complement negate.
- Sub-module div_step: combinational single-iteration restoring stage. Parametrised by WIDTH; inputs partial remainder, next dividend bit, divisor magnitude; outputs new remainder and quotient bit.
- Top: FSM, counter, operand/result registers, sign fix-up.

## Test plan
- WIDTH=8, unsigned 200 / 7 → quotient 28, remainder 4, out_valid exactly 9 edges after accept, div_by_zero 0.
- WIDTH=8, signed -100 / 7 → quotient -14 (0xF2), remainder -2 (0xFE); signed 100 / -7 → quotient 0xF2, remainder 0x02.
- WIDTH=8, divisor 0, dividend 0x5A → quotient 0xFF, remainder 0x5A, div_by_zero 1, out_valid one edge after accept.
- WIDTH=8, signed 0x80 / 0xFF → quotient 0x80, remainder 0x00, div_by_zero 0.
- Back-pressure: hold out_ready low 5 cycles → outputs stable, in_ready low. Then raise out_ready with in_valid high → new op accepted the same edge, next result WIDTH+1 edges later.
- WIDTH=64, reset asserted mid-RUN → next edge state IDLE, all outputs 0, in_ready 1. Subsequent op 2^64-1 / 3 → quotient 0x5555555555555555, remainder 0.
